// File: rtl/fft8_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_frame_loader_if
//  Purpose  : Bundles the sample stream, held-frame bus and status signals
//             between the fft8 frame loader and its neighbours.
//  Ports    : in_valid/in_ready/in_real/in_imag/in_last  - serial sample stream
//             frame_real/frame_imag/frame_valid/frame_ready - held 8-lane frame
//             fill_cnt  - index of next sample to be written
//             frame_err - one-cycle pulse on in_last misalignment
//  Modports : master - upstream sender / downstream consumer side
//             slave  - the frame loader itself
//  Revision : 1.0  initial release
// ============================================================================
interface fft8_frame_loader_if #(
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_real;
    logic [DATA_W-1:0]     in_imag;
    logic                  in_last;
    logic [8*DATA_W-1:0]   frame_real;
    logic [8*DATA_W-1:0]   frame_imag;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [2:0]            fill_cnt;
    logic                  frame_err;

    modport master (
        output in_valid, in_real, in_imag, in_last, frame_ready,
        input  in_ready, frame_real, frame_imag, frame_valid, fill_cnt, frame_err
    );

    modport slave (
        input  in_valid, in_real, in_imag, in_last, frame_ready,
        output in_ready, frame_real, frame_imag, frame_valid, fill_cnt, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/fft8_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_frame_loader
//  Purpose  : Serial-to-parallel feeder for a combinational 8-point FFT.
//             Complex samples arrive one per accepted cycle, are collected
//             into an 8-entry fill buffer, then moved as a whole into a hold
//             buffer whose lanes drive fft8 in_k_real / in_k_imag directly.
//             While one frame is held, the next one streams into the fill
//             buffer (fill + hold double buffering).
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - fft8_frame_loader_if.slave (sample stream in,
//                      held frame out, fill_cnt and frame_err status)
//  Params   : DATA_W     - real/imag sample width (Q(DATA_W-8).8, passed raw)
//             CHECK_LAST - 1: check in_last against sample index 7
//  Revision : 1.0  initial release
// ============================================================================
module fft8_frame_loader #(
    parameter int DATA_W     = 32,
    parameter bit CHECK_LAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft8_frame_loader_if.slave   bus
);

    localparam int         c_LANES    = 8;
    localparam logic [2:0] c_LAST_IDX = 3'd7;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_LANES*DATA_W-1:0] r_fill_real;
    logic [c_LANES*DATA_W-1:0] r_fill_imag;
    logic [c_LANES*DATA_W-1:0] r_hold_real;
    logic [c_LANES*DATA_W-1:0] r_hold_imag;
    logic [2:0]                r_fill_cnt;
    logic                      r_fill_full;
    logic                      r_frame_valid;
    logic                      r_frame_err;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                      w_accept;
    logic                      w_transfer;
    logic                      w_consume;
    logic                      w_at_last_idx;
    logic                      w_early_last;
    logic                      w_missing_last;
    logic [c_LANES-1:0]        w_lane_we;

    // in_ready depends only on state so upstream never sees a
    // combinational path from its own in_valid.
    assign bus.in_ready   = !r_fill_full;
    assign w_accept       = bus.in_valid && !r_fill_full;
    assign w_consume      = r_frame_valid && bus.frame_ready;
    // Hold buffer is free when empty or being consumed on this same edge,
    // which lets a new frame replace the old one without a bubble.
    assign w_transfer     = r_fill_full && (!r_frame_valid || bus.frame_ready);

    assign w_at_last_idx  = (r_fill_cnt == c_LAST_IDX);
    assign w_early_last   = CHECK_LAST && bus.in_last && !w_at_last_idx;
    assign w_missing_last = CHECK_LAST && !bus.in_last;

    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane_we
            assign w_lane_we[k] = w_accept && (r_fill_cnt == 3'(k));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fill buffer: written one lane per accepted sample. Contents after a
    // misaligned in_last are don't-care; they get overwritten from lane 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_real <= '0;
            r_fill_imag <= '0;
        end else begin
            for (int k = 0; k < c_LANES; k++) begin
                if (w_lane_we[k]) begin
                    r_fill_real[k*DATA_W +: DATA_W] <= bus.in_real;
                    r_fill_imag[k*DATA_W +: DATA_W] <= bus.in_imag;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill index, fill-full flag and framing error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= 3'd0;
            r_fill_full <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // accept and transfer are mutually exclusive: accept needs
            // !fill_full, transfer needs fill_full.
            if (w_accept) begin
                if (w_early_last) begin
                    // Partial frame is abandoned; restart at lane 0.
                    r_fill_cnt  <= 3'd0;
                    r_frame_err <= 1'b1;
                end else if (w_at_last_idx) begin
                    // Frame still completes even when in_last is absent.
                    r_fill_cnt  <= 3'd0;
                    r_fill_full <= 1'b1;
                    r_frame_err <= w_missing_last;
                end else begin
                    r_fill_cnt  <= r_fill_cnt + 3'd1;
                end
            end else if (w_transfer) begin
                r_fill_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold buffer: changes only on transfer, so the frame is stable for
    // as long as it waits for frame_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_real   <= '0;
            r_hold_imag   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_hold_real   <= r_fill_real;
                r_hold_imag   <= r_fill_imag;
                r_frame_valid <= 1'b1;
            end else if (w_consume) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.frame_real  = r_hold_real;
    assign bus.frame_imag  = r_hold_imag;
    assign bus.frame_valid = r_frame_valid;
    assign bus.fill_cnt    = r_fill_cnt;
    assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fft8_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft8_frame_loader
//  Purpose  : Self-checking bench for fft8_frame_loader. Drivers push each
//             complete frame to a scoreboard queue; a negedge monitor pops
//             and compares whenever the held frame is consumed, and also
//             checks that a stalled frame stays put.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft8_frame_loader;

    localparam int DATA_W = 32;
    localparam int FW     = 8 * DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft8_frame_loader_if #(.DATA_W(DATA_W)) bus ();

    fft8_frame_loader #(
        .DATA_W     (DATA_W),
        .CHECK_LAST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2*FW-1:0] sb_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: scoreboard pop on consume, stability while stalled
    // ------------------------------------------------------------------
    logic            prev_stall = 1'b0;
    logic [2*FW-1:0] prev_frame = '0;
    logic [2*FW-1:0] mon_cur;
    logic [2*FW-1:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_cur = {bus.frame_real, bus.frame_imag};
            if (prev_stall) begin
                n_tests++;
                if (bus.frame_valid !== 1'b1 || mon_cur !== prev_frame) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b frame=%h required valid=1 frame=%h",
                             bus.frame_valid, mon_cur, prev_frame);
                end
            end
            if (bus.frame_valid === 1'b1 && bus.frame_ready === 1'b1) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: frame=%h with no frame expected", mon_cur);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb_frame: got %h required %h", mon_cur, mon_exp);
                    end
                end
            end
            prev_stall = bus.frame_valid && !bus.frame_ready;
            prev_frame = mon_cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Drivers (called at posedge+1, return at posedge+1 after the accept)
    // ------------------------------------------------------------------
    task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                        input logic last);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_real  = re;
        bus.in_imag  = im;
        bus.in_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready=%b required 1 within 2000 cycles", bus.in_ready);
                acc = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] re, input logic [FW-1:0] im,
                              input int last_pos, input bit push, input bit gaps);
        if (push) sb_q.push_back({re, im});
        for (int k = 0; k < 8; k++) begin
            while (gaps && $urandom_range(1, 0) == 0) begin
                @(posedge clk);
                #1;
            end
            send(re[k*DATA_W +: DATA_W], im[k*DATA_W +: DATA_W], (k == last_pos));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.frame_ready = 1'b1;
        while ((sb_q.size() != 0 || bus.frame_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_tests++;
        if (sb_q.size() != 0 || bus.frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d frame_valid=%b required 0 and 0",
                     sb_q.size(), bus.frame_valid);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.in_valid    = 1'b0;
        bus.in_real     = '0;
        bus.in_imag     = '0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        n_tests++; if (bus.fill_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_fill_cnt: got %0d required 0", bus.fill_cnt); end
        n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b required 0", bus.frame_valid); end
        n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
        n_tests++; if ({bus.frame_real, bus.frame_imag} !== '0) begin n_fail++; $display("FAIL reset_frame_data: got %h required 0", {bus.frame_real, bus.frame_imag}); end
    endtask

    task automatic test_single_frame();
        logic [FW-1:0] re;
        int            sum;
        for (int k = 0; k < 8; k++) re[k*DATA_W +: DATA_W] = DATA_W'(k * 256);
        bus.frame_ready = 1'b1;
        send_frame(re, re, 7, 1'b1, 1'b0);
        n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: frame_valid=%b required 0", bus.frame_valid); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_full_ready: in_ready=%b required 0", bus.in_ready); end
        n_tests++; if (bus.fill_cnt !== 3'd0) begin n_fail++; $display("FAIL single_wrap: fill_cnt=%0d required 0", bus.fill_cnt); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: frame_valid=%b required 1", bus.frame_valid); end
        n_tests++; if (bus.frame_real !== re || bus.frame_imag !== re) begin n_fail++; $display("FAIL single_lanes: real=%h imag=%h required %h", bus.frame_real, bus.frame_imag, re); end
        sum = 0;
        for (int k = 0; k < 8; k++) sum += $signed(bus.frame_real[k*DATA_W +: DATA_W]);
        n_tests++; if (sum != 7168) begin n_fail++; $display("FAIL single_out0: got %0d required 7168", sum); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] are, aim, bre, bim;
        int            ta, tb;
        for (int k = 0; k < 8; k++) begin
            are[k*DATA_W +: DATA_W] = DATA_W'((2*k + 1) * 256);
            aim[k*DATA_W +: DATA_W] = DATA_W'((2*k + 2) * 256);
            bre[k*DATA_W +: DATA_W] = DATA_W'((2*k + 1) * 256 + 32'h0001_0000);
            bim[k*DATA_W +: DATA_W] = DATA_W'((2*k + 2) * 256 + 32'h0002_0000);
        end
        bus.frame_ready = 1'b0;
        send_frame(are, aim, 7, 1'b1, 1'b0);
        ta = cyc;
        send_frame(bre, bim, 7, 1'b1, 1'b0);
        tb = cyc;
        n_tests++; if (tb - ta != 9) begin n_fail++; $display("FAIL b2b_cadence: got %0d cycles required 9", tb - ta); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_low: got %b required 0", bus.in_ready); end
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (bus.frame_valid !== 1'b1 || bus.frame_real !== are || bus.frame_imag !== aim) begin n_fail++; $display("FAIL b2b_first_held: valid=%b real=%h required 1 %h", bus.frame_valid, bus.frame_real, are); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %b required 0", bus.in_ready); end
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.frame_valid !== 1'b1 || bus.frame_real !== bre || bus.frame_imag !== bim) begin n_fail++; $display("FAIL b2b_second: valid=%b real=%h required 1 %h", bus.frame_valid, bus.frame_real, bre); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b required 1", bus.in_ready); end
        drain();
    endtask

    task automatic test_last_errors();
        logic [FW-1:0] cre, dre, ere;
        for (int k = 0; k < 8; k++) begin
            cre[k*DATA_W +: DATA_W] = 32'hC000_0000 + DATA_W'(k);
            dre[k*DATA_W +: DATA_W] = 32'hD000_0000 + DATA_W'(k);
            ere[k*DATA_W +: DATA_W] = 32'hE000_0000 + DATA_W'(k);
        end
        bus.frame_ready = 1'b0;
        send_frame(cre, ~cre, 7, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) send(32'hDEAD_0000 + DATA_W'(k), 32'hBEEF_0000, (k == 4));
        n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL early_last_err: got %b required 1", bus.frame_err); end
        n_tests++; if (bus.fill_cnt !== 3'd0) begin n_fail++; $display("FAIL early_last_cnt: got %0d required 0", bus.fill_cnt); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b required 0", bus.frame_err); end
        send_frame(dre, ~dre, 7, 1'b1, 1'b0);
        n_tests++; if (bus.frame_real !== cre || bus.frame_imag !== ~cre) begin n_fail++; $display("FAIL err_hold_untouched: got %h required %h", bus.frame_real, cre); end
        n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_frame_err: got %b required 0", bus.frame_err); end
        drain();
        send_frame(ere, ~ere, -1, 1'b1, 1'b0);
        n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_last_err: got %b required 1", bus.frame_err); end
        drain();
    endtask

    task automatic test_random();
        logic [FW-1:0] rre, rim;
        bit            done;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    for (int k = 0; k < 8; k++) begin
                        rre[k*DATA_W +: DATA_W] = $urandom;
                        rim[k*DATA_W +: DATA_W] = $urandom;
                    end
                    send_frame(rre, rim, 7, 1'b1, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.frame_ready = ($urandom_range(99, 0) < 30);
                end
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] fre, gre;
        for (int k = 0; k < 8; k++) begin
            fre[k*DATA_W +: DATA_W] = 32'hF000_0000 + DATA_W'(k);
            gre[k*DATA_W +: DATA_W] = 32'h0A00_0000 + DATA_W'(k);
        end
        bus.frame_ready = 1'b0;
        send_frame(fre, fre, 7, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) send(32'h5555_0000 + DATA_W'(k), 32'h0, 1'b0);
        n_tests++; if (bus.fill_cnt !== 3'd5 || bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: fill_cnt=%0d valid=%b required 5 1", bus.fill_cnt, bus.frame_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.frame_valid !== 1'b0 || bus.fill_cnt !== 3'd0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctrl: valid=%b cnt=%0d err=%b required 0 0 0", bus.frame_valid, bus.fill_cnt, bus.frame_err); end
        n_tests++; if ({bus.frame_real, bus.frame_imag} !== '0) begin n_fail++; $display("FAIL async_reset_data: got %h required 0", {bus.frame_real, bus.frame_imag}); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", bus.in_ready); end
        bus.frame_ready = 1'b1;
        send(gre[DATA_W-1:0], ~gre[DATA_W-1:0], 1'b0);
        n_tests++; if (bus.fill_cnt !== 3'd1) begin n_fail++; $display("FAIL post_reset_index: fill_cnt=%0d required 1", bus.fill_cnt); end
        sb_q.push_back({gre, ~gre});
        for (int k = 1; k < 8; k++) send(gre[k*DATA_W +: DATA_W], ~gre[k*DATA_W +: DATA_W], (k == 7));
        drain();
    endtask

    task automatic test_negative();
        logic [FW-1:0] re, im;
        for (int k = 0; k < 8; k++) begin
            re[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            im[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        end
        bus.frame_ready = 1'b1;
        send_frame(re, im, 7, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        n_tests++; if (bus.frame_real !== re || bus.frame_imag !== im) begin n_fail++; $display("FAIL negative_bits: real=%h imag=%h required %h %h", bus.frame_real, bus.frame_imag, re, im); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_last_errors();
        test_random();
        test_reset_mid();
        test_negative();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
